// File: rtl/arbitro_botones_if.sv
// Action handshake between the button arbiter and the pet state machine.
// The master presents an action code and the slave accepts it with ack.
interface arbitro_botones_if;
   logic       accion_valid;
   logic [1:0] accion;
   logic       accion_ack;

   modport master (
      output accion_valid,
      output accion,
      input  accion_ack
   );

   modport slave (
      input  accion_valid,
      input  accion,
      output accion_ack
   );
endinterface

// File: rtl/arbitro_botones.sv
// Synchronizes and debounces three raw buttons, then arbitrates their pending
// requests into one action at a time, with test mode toggled by a long press.
module arbitro_botones #(
   parameter int unsigned DEBOUNCE_CYCLES  = 500000,
   parameter int unsigned TEST_HOLD_CYCLES = 250000000
) (
   input  logic                clk,
   input  logic                reset,
   input  logic                Boton_Comida,
   input  logic                Boton_Medicina,
   input  logic                Boton_Test,
   arbitro_botones_if.master   accion_bus,
   output logic                modo_test,
   output logic [2:0]          pendiente
);

   localparam int unsigned DW = $clog2(DEBOUNCE_CYCLES + 1);
   localparam int unsigned HW = $clog2(TEST_HOLD_CYCLES + 1);
   localparam logic [DW-1:0] DEB_LAST  = DW'(DEBOUNCE_CYCLES - 1);
   localparam logic [HW-1:0] HOLD_LAST = HW'(TEST_HOLD_CYCLES - 1);
   localparam logic [HW-1:0] HOLD_MAX  = HW'(TEST_HOLD_CYCLES);
   localparam int TEST = 2;

   typedef enum logic {IDLE, GRANT} state_t;

   state_t        state_q, state_d;
   logic [2:0]    sync1_q, sync2_q;
   logic [2:0]    deb_q, deb_d;
   logic [1:0]    debPrev_q;
   logic [DW-1:0] debCnt_q [3];
   logic [DW-1:0] debCnt_d [3];
   logic [HW-1:0] holdCnt_q, holdCnt_d;
   logic          holdSet;
   logic [2:0]    pend_q, pend_d, pendSet, pendClr;
   logic [1:0]    accion_q, accion_d;
   logic          rrMed_q, rrMed_d;
   logic          modo_q, modo_d;

   // The counter only advances on the D-th consecutive differing cycle it flips the level.
   always_comb begin
      for (int i = 0; i < 3; i++) begin
         deb_d[i]    = deb_q[i];
         debCnt_d[i] = '0;
         if (sync2_q[i] != deb_q[i]) begin
            if (debCnt_q[i] == DEB_LAST) begin
               deb_d[i] = ~deb_q[i];
            end else begin
               debCnt_d[i] = debCnt_q[i] + 1'b1;
            end
         end
      end
   end

   always_comb begin
      holdCnt_d = holdCnt_q;
      holdSet   = 1'b0;
      if (!deb_q[TEST]) begin
         holdCnt_d = '0;
      end else if (holdCnt_q != HOLD_MAX) begin
         holdCnt_d = holdCnt_q + 1'b1;
         holdSet   = (holdCnt_q == HOLD_LAST);
      end
   end

   assign pendSet = {holdSet, deb_q[1:0] & ~debPrev_q};

   // rrMed_q set means medicina wins the next comida/medicina tie.
   always_comb begin
      state_d  = state_q;
      accion_d = accion_q;
      rrMed_d  = rrMed_q;
      modo_d   = modo_q;
      pendClr  = '0;
      case (state_q)
         IDLE: begin
            if (|pend_q) begin
               state_d = GRANT;
               if (pend_q[2]) begin
                  accion_d = 2'b11;
               end else if (pend_q[0] && (!pend_q[1] || !rrMed_q)) begin
                  accion_d = 2'b01;
               end else begin
                  accion_d = 2'b10;
               end
            end
         end
         GRANT: begin
            if (accion_bus.accion_ack) begin
               state_d  = IDLE;
               accion_d = 2'b00;
               case (accion_q)
                  2'b01: begin
                     pendClr[0] = 1'b1;
                     rrMed_d    = 1'b1;
                  end
                  2'b10: begin
                     pendClr[1] = 1'b1;
                     rrMed_d    = 1'b0;
                  end
                  2'b11: begin
                     pendClr[2] = 1'b1;
                     modo_d     = ~modo_q;
                  end
                  default: ;
               endcase
            end
         end
         default: state_d = IDLE;
      endcase
      pend_d = (pend_q & ~pendClr) | pendSet;
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q   <= IDLE;
         sync1_q   <= '0;
         sync2_q   <= '0;
         deb_q     <= '0;
         debPrev_q <= '0;
         for (int i = 0; i < 3; i++) debCnt_q[i] <= '0;
         holdCnt_q <= '0;
         pend_q    <= '0;
         accion_q  <= 2'b00;
         rrMed_q   <= 1'b0;
         modo_q    <= 1'b0;
      end else begin
         state_q   <= state_d;
         sync1_q   <= {Boton_Test, Boton_Medicina, Boton_Comida};
         sync2_q   <= sync1_q;
         deb_q     <= deb_d;
         debPrev_q <= deb_q[1:0];
         for (int i = 0; i < 3; i++) debCnt_q[i] <= debCnt_d[i];
         holdCnt_q <= holdCnt_d;
         pend_q    <= pend_d;
         accion_q  <= accion_d;
         rrMed_q   <= rrMed_d;
         modo_q    <= modo_d;
      end
   end

   assign accion_bus.accion_valid = (state_q == GRANT);
   assign accion_bus.accion       = accion_q;
   assign modo_test               = modo_q;
   assign pendiente               = pend_q;

endmodule

// File: tb/tb_arbitro_botones.sv
// Bench for arbitro_botones with short debounce/hold windows; every accepted
// action is popped from a queue of expected action codes.
module tb_arbitro_botones;

   localparam int unsigned DEB  = 4;
   localparam int unsigned HOLD = 20;

   logic       clk = 1'b0;
   logic       reset;
   logic       Boton_Comida, Boton_Medicina, Boton_Test;
   logic       modo_test;
   logic [2:0] pendiente;
   int         checks = 0;
   int         errors = 0;
   logic [1:0] expQ [$];

   arbitro_botones_if bus ();

   arbitro_botones #(
      .DEBOUNCE_CYCLES  (DEB),
      .TEST_HOLD_CYCLES (HOLD)
   ) dut (
      .clk            (clk),
      .reset          (reset),
      .Boton_Comida   (Boton_Comida),
      .Boton_Medicina (Boton_Medicina),
      .Boton_Test     (Boton_Test),
      .accion_bus     (bus),
      .modo_test      (modo_test),
      .pendiente      (pendiente)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [2:0] buttons;
      int         holdCycles;
      int         nExp;
      logic [5:0] expSeq;
      logic       expModo;
   } vec_t;

   task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
      checks++;
      if (actual !== expected) begin
         errors++;
         $display("[TB] FAIL %s actual=%0h expected=%0h", name, actual, expected);
      end
   endtask

   task automatic waitCycles(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic setButtons(input logic [2:0] b);
      {Boton_Test, Boton_Medicina, Boton_Comida} = b;
   endtask

   // An accepted handshake completes on the next rising edge.
   always @(negedge clk) begin
      if (reset && bus.accion_valid && bus.accion_ack) begin
         if (expQ.size() == 0) begin
            checks++;
            errors++;
            $display("[TB] FAIL grant_unexpected actual=%0h expected=none", bus.accion);
         end else begin
            checkOutput("grant_code", {30'd0, bus.accion}, {30'd0, expQ.pop_front()});
         end
      end
   end

   task automatic applyStimulus(input vec_t v, input int idx);
      for (int k = 0; k < v.nExp; k++) expQ.push_back(v.expSeq[2*k +: 2]);
      setButtons(v.buttons);
      waitCycles(v.holdCycles);
      setButtons(3'b000);
      waitCycles(40);
      $display("[TB] vector %0d done", idx);
      checkOutput("vec_drain", expQ.size(), 0);
      checkOutput("vec_modo", {31'd0, modo_test}, {31'd0, v.expModo});
      checkOutput("vec_pend", {29'd0, pendiente}, 32'd0);
   endtask

   initial begin
      #200000;
      $display("[TB] FAIL watchdog timeout");
      $fatal(1, "[TB] simulation time limit reached");
   end

   initial begin
      vec_t vecs [8];
      int   n;
      logic bad;

      vecs[0] = '{3'b001, 10, 1, 6'b000001, 1'b0};
      vecs[1] = '{3'b010, 10, 1, 6'b000010, 1'b0};
      vecs[2] = '{3'b001,  3, 0, 6'b000000, 1'b0};
      vecs[3] = '{3'b100, 10, 0, 6'b000000, 1'b0};
      vecs[4] = '{3'b100, 30, 1, 6'b000011, 1'b1};
      vecs[5] = '{3'b100, 30, 1, 6'b000011, 1'b0};
      vecs[6] = '{3'b011, 10, 2, 6'b001001, 1'b0};
      vecs[7] = '{3'b111, 30, 3, 6'b111001, 1'b1};

      reset = 1'b0;
      setButtons(3'b000);
      bus.accion_ack = 1'b0;
      waitCycles(3);
      checkOutput("rst_valid", {31'd0, bus.accion_valid}, 32'd0);
      checkOutput("rst_accion", {30'd0, bus.accion}, 32'd0);
      checkOutput("rst_modo", {31'd0, modo_test}, 32'd0);
      checkOutput("rst_pend", {29'd0, pendiente}, 32'd0);
      reset = 1'b1;
      bus.accion_ack = 1'b1;
      waitCycles(2);

      for (int i = 0; i < 8; i++) applyStimulus(vecs[i], i);

      // Stalled grant: both flags set, acknowledgement withheld.
      bus.accion_ack = 1'b0;
      expQ.push_back(2'b01);
      expQ.push_back(2'b10);
      setButtons(3'b011);
      n = 0;
      while (!bus.accion_valid && n < 40) begin
         waitCycles(1);
         n++;
      end
      setButtons(3'b000);
      checkOutput("stall_valid_seen", {31'd0, bus.accion_valid}, 32'd1);
      bad = 1'b0;
      for (int i = 0; i < 10; i++) begin
         waitCycles(1);
         if (!bus.accion_valid || bus.accion !== 2'b01) bad = 1'b1;
      end
      checkOutput("stall_hold_01", {31'd0, bad}, 32'd0);
      bus.accion_ack = 1'b1;
      waitCycles(1);
      checkOutput("stall_idle_gap", {31'd0, bus.accion_valid}, 32'd0);
      waitCycles(1);
      checkOutput("stall_second_valid", {31'd0, bus.accion_valid}, 32'd1);
      checkOutput("stall_second_code", {30'd0, bus.accion}, 32'd2);
      waitCycles(20);
      checkOutput("stall_drain", expQ.size(), 0);

      // Latency from a raw rise to the presented action.
      expQ.push_back(2'b01);
      Boton_Comida = 1'b1;
      n = 0;
      do begin
         waitCycles(1);
         n++;
      end while (!bus.accion_valid && n < 40);
      checkOutput("lat_edges", n, DEB + 4);
      checkOutput("lat_code", {30'd0, bus.accion}, 32'd1);
      waitCycles(1);
      checkOutput("lat_one_cycle", {31'd0, bus.accion_valid}, 32'd0);
      Boton_Comida = 1'b0;
      waitCycles(20);
      checkOutput("lat_pend", {29'd0, pendiente}, 32'd0);
      checkOutput("lat_drain", expQ.size(), 0);

      // Short pulse and glitches never make it through the debouncer.
      bad = 1'b0;
      Boton_Comida = 1'b1;
      for (int i = 0; i < 3; i++) begin
         waitCycles(1);
         bad |= bus.accion_valid;
      end
      for (int g = 0; g < 6; g++) begin
         Boton_Comida = 1'b0;
         for (int i = 0; i < 2; i++) begin
            waitCycles(1);
            bad |= bus.accion_valid;
         end
         Boton_Comida = 1'b1;
         waitCycles(1);
         bad |= bus.accion_valid;
      end
      Boton_Comida = 1'b0;
      for (int i = 0; i < 15; i++) begin
         waitCycles(1);
         bad |= bus.accion_valid;
      end
      checkOutput("glitch_no_valid", {31'd0, bad}, 32'd0);
      checkOutput("glitch_pend", {29'd0, pendiente}, 32'd0);

      // Reset in the middle of a test-mode grant abandons it.
      bus.accion_ack = 1'b0;
      Boton_Test = 1'b1;
      n = 0;
      while (!bus.accion_valid && n < 80) begin
         waitCycles(1);
         n++;
      end
      checkOutput("rst_grant_code", {30'd0, bus.accion}, 32'd3);
      reset = 1'b0;
      Boton_Test = 1'b0;
      Boton_Comida = 1'b1;
      #1;
      checkOutput("rstg_valid", {31'd0, bus.accion_valid}, 32'd0);
      checkOutput("rstg_accion", {30'd0, bus.accion}, 32'd0);
      checkOutput("rstg_modo", {31'd0, modo_test}, 32'd0);
      checkOutput("rstg_pend", {29'd0, pendiente}, 32'd0);
      waitCycles(3);
      bus.accion_ack = 1'b1;
      expQ.push_back(2'b01);
      reset = 1'b1;
      waitCycles(30);
      checkOutput("rstg_fresh_drain", expQ.size(), 0);
      checkOutput("rstg_modo_after", {31'd0, modo_test}, 32'd0);
      Boton_Comida = 1'b0;
      waitCycles(30);
      checkOutput("rstg_final_pend", {29'd0, pendiente}, 32'd0);
      checkOutput("rstg_final_drain", expQ.size(), 0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
